// File: rtl/keypad_scan_zyq.sv
// rtl/keypad_scan_zyq.sv - matrix keypad scanner: per-scan debounce, single-key event, multi-key flag
// Optional auto-repeat of the held key when KEYPAD_REPEAT_EN is defined.
module keypad_scan_zyq #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CODE_W       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ROWS-1:0]   i_row_in,
  output logic [COLS-1:0]   o_col_out,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_key_held,
  output logic              o_multi
);

  localparam int KEYS   = ROWS * COLS;
  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int COL_W  = $clog2(COLS);
  localparam int STAB_W = $clog2(DEBOUNCE + 1);

  if (KEYS > (1 << CODE_W) || SCAN_DIV < 3 || DEBOUNCE < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan_zyq: illegal parameter combination");
  end

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
  typedef enum logic {ST_IDLE, ST_PRESSED} state_t;

  logic [ROWS-1:0]   r_row_s1, r_row_s2;
  logic [TICK_W-1:0] r_tick;
  logic [COL_W-1:0]  r_col;
  logic [KEYS-1:0]   r_image;
  logic [KEYS-1:0]   w_image_next;
  logic              w_sample, w_scan_done;
  logic [1:0]        w_count;
  logic [CODE_W-1:0] w_code, w_key;
  cls_t              w_cls;
  logic              w_same, w_stable;
  logic [STAB_W-1:0] w_stab_next;

  state_t            r_state;
  cls_t              r_prev_cls;
  logic [CODE_W-1:0] r_prev_key;
  logic [STAB_W-1:0] r_stab;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid, r_key_held, r_multi;

  // Rows are asynchronous to the clock; 2-FF synchroniser, idle level is all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= i_row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_sample    = (r_tick == TICK_W'(SCAN_DIV - 1));
  assign w_scan_done = w_sample && (r_col == COL_W'(COLS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick  <= '0;
      r_col   <= '0;
      r_image <= '0;
    end else begin
      r_image <= w_image_next;
      if (w_sample) begin
        r_tick <= '0;
        r_col  <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      o_col_out[c] = (r_col != COL_W'(c));
    end
  end

  // Merge the column being sampled now so scan-done classifies the complete image.
  always_comb begin
    w_image_next = r_image;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_sample && (r_col == COL_W'(c))) begin
          w_image_next[r*COLS + c] = ~r_row_s2[r];
        end
      end
    end
  end

  always_comb begin
    w_count = 2'd0;
    w_code  = '0;
    for (int k = 0; k < KEYS; k++) begin
      if (w_image_next[k]) begin
        if (w_count != 2'd2) begin
          w_count = w_count + 2'd1;
        end
        w_code = CODE_W'(k);
      end
    end
  end

  always_comb begin
    case (w_count)
      2'd0:    w_cls = CLS_NONE;
      2'd1:    w_cls = CLS_SINGLE;
      default: w_cls = CLS_MULTI;
    endcase
  end

  // Key field is zeroed unless SINGLE so one equality compares the whole classification.
  assign w_key       = (w_count == 2'd1) ? w_code : '0;
  assign w_same      = (w_cls == r_prev_cls) && (w_key == r_prev_key);
  assign w_stab_next = !w_same ? STAB_W'(1) :
                       (r_stab == STAB_W'(DEBOUNCE)) ? r_stab : r_stab + STAB_W'(1);
  assign w_stable    = (w_stab_next == STAB_W'(DEBOUNCE));

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep;
  logic             r_rep_first;
  logic [REP_W-1:0] w_rep_next;
  logic [REP_W-1:0] w_rep_target;

  assign w_rep_next   = r_rep + REP_W'(1);
  assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_prev_cls  <= CLS_NONE;
      r_prev_key  <= '0;
      r_stab      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        r_multi    <= (w_cls == CLS_MULTI);
        r_stab     <= w_stab_next;
        r_prev_cls <= w_cls;
        r_prev_key <= w_key;
        case (r_state)
          ST_IDLE: begin
            if (w_stable && (w_cls == CLS_SINGLE)) begin
              r_state     <= ST_PRESSED;
              r_key_code  <= w_key;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              r_rep       <= '0;
              r_rep_first <= 1'b1;
`endif
            end
          end
          ST_PRESSED: begin
            if (w_stable && (w_cls == CLS_NONE)) begin
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
            end
`ifdef KEYPAD_REPEAT_EN
            // Any scan that is not the committed key held stable restarts the repeat delay.
            else if (w_stable && (w_cls == CLS_SINGLE) && (w_key == r_key_code)) begin
              if (w_rep_next == w_rep_target) begin
                r_key_valid <= 1'b1;
                r_rep       <= '0;
                r_rep_first <= 1'b0;
              end else begin
                r_rep <= w_rep_next;
              end
            end else begin
              r_rep       <= '0;
              r_rep_first <= 1'b1;
            end
`endif
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;
  assign o_multi     = r_multi;

endmodule

// File: tb/tb_keypad_scan_zyq.sv
// tb/tb_keypad_scan_zyq.sv - self-checking bench for keypad_scan_zyq against a scan-level key model
module tb_keypad_scan_zyq;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RD       = 5;
  localparam int RR       = 2;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid, key_held, multi;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  int hist[$];
  bit m_held;
  int m_code;
  int m_n;
  int e_valid;
  bit e_multi;

  keypad_scan_zyq #(
    .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_row_in(row_in), .o_col_out(col_out),
    .o_key_code(key_code), .o_key_valid(key_valid), .o_key_held(key_held), .o_multi(multi)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic void model_reset();
    hist.delete();
    m_held = 0;
    m_code = 0;
    m_n    = 0;
  endfunction

  // One complete scan with key set k: classify, require DEB identical scans, then apply press/release rules.
  function automatic void model_scan(input logic [15:0] k);
    int pc, cls;
    bit stable;
    pc  = $countones(k);
    cls = -1;
    if (pc > 1) cls = -2;
    else for (int i = 0; i < 16; i++) if (k[i]) cls = i;
    hist.push_back(cls);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != cls) stable = 0;
    e_multi = (pc > 1);
    e_valid = 0;
    if (!m_held) begin
      if (stable && cls >= 0) begin
        m_held = 1; m_code = cls; e_valid = 1; m_n = 0;
      end
    end else if (stable && cls == -1) begin
      m_held = 0;
    end else if (stable && cls == m_code) begin
      m_n++;
`ifdef KEYPAD_REPEAT_EN
      if (m_n == RD || (m_n > RD && (m_n - RD) % RR == 0)) e_valid = 1;
`endif
    end else begin
      m_n = 0;
    end
  endfunction

  task automatic do_scan(input logic [15:0] k, output int vcnt);
    keys = k;
    vcnt = 0;
    repeat (SCAN) begin
      @(posedge clk); #1;
      if (key_valid) vcnt++;
    end
    model_scan(k);
  endtask

  task automatic test_reset();
    int vcnt;
    @(posedge clk); #3;
    checks++; if (key_valid !== 1'b0 || key_held !== 1'b0 || multi !== 1'b0) begin errors++; $display("FAIL reset_flags: got v=%b h=%b m=%b want 0 0 0", key_valid, key_held, multi); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    keys = '0;
    vcnt = 0;
    for (int n = 1; n <= SCAN; n++) begin
      logic [3:0] exp_col;
      @(posedge clk); #1;
      if (key_valid) vcnt++;
      exp_col = 4'b1111 ^ (4'b0001 << ((n / SCAN_DIV) % 4));
      checks++; if (col_out !== exp_col) begin errors++; $display("FAIL col_walk cycle %0d: got %b want %b", n, col_out, exp_col); end
    end
    model_scan('0);
    checks++; if (vcnt != e_valid || key_held !== m_held || multi !== e_multi) begin errors++; $display("FAIL idle_scan: got v=%0d h=%b m=%b want %0d %b %b", vcnt, key_held, multi, e_valid, m_held, e_multi); end
  endtask

  task automatic test_single_press();
    int vcnt;
    for (int s = 0; s < 11; s++) begin
      do_scan((s < 6) ? 16'h0200 : 16'h0000, vcnt);
      checks++; if (vcnt != e_valid) begin errors++; $display("FAIL single_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
      checks++; if (key_held !== m_held) begin errors++; $display("FAIL single_held scan %0d: got %b want %b", s, key_held, m_held); end
      checks++; if (key_code !== 4'(m_code)) begin errors++; $display("FAIL single_code scan %0d: got %0d want %0d", s, key_code, m_code); end
      checks++; if (multi !== e_multi) begin errors++; $display("FAIL single_multi scan %0d: got %b want %b", s, multi, e_multi); end
    end
  endtask

  task automatic test_bounce();
    int vcnt;
    for (int s = 0; s < 10; s++) begin
      do_scan((s % 2 == 0) ? 16'h0200 : 16'h0000, vcnt);
      checks++; if (vcnt != e_valid) begin errors++; $display("FAIL bounce_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
      checks++; if (key_held !== m_held) begin errors++; $display("FAIL bounce_held scan %0d: got %b want %b", s, key_held, m_held); end
    end
  endtask

  task automatic test_multi();
    int vcnt;
    for (int s = 0; s < 12; s++) begin
      do_scan((s < 3) ? 16'h8001 : (s < 8) ? 16'h8000 : 16'h0000, vcnt);
      checks++; if (multi !== e_multi) begin errors++; $display("FAIL multi_flag scan %0d: got %b want %b", s, multi, e_multi); end
      checks++; if (vcnt != e_valid) begin errors++; $display("FAIL multi_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
      checks++; if (key_held !== m_held) begin errors++; $display("FAIL multi_held scan %0d: got %b want %b", s, key_held, m_held); end
      checks++; if (key_code !== 4'(m_code)) begin errors++; $display("FAIL multi_code scan %0d: got %0d want %0d", s, key_code, m_code); end
    end
  endtask

  task automatic test_reset_mid_press();
    int vcnt;
    for (int s = 0; s < 4; s++) do_scan(16'h0020, vcnt);
    checks++; if (key_held !== 1'b1 || key_code !== 4'd5) begin errors++; $display("FAIL pre_reset_hold: got h=%b code=%0d want 1 5", key_held, key_code); end
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (key_held !== 1'b0 || key_valid !== 1'b0 || multi !== 1'b0 || key_code !== 4'd0) begin errors++; $display("FAIL async_reset: got h=%b v=%b m=%b code=%0d want all 0", key_held, key_valid, multi, key_code); end
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL async_reset_col: got %b want 1110", col_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 9; s++) begin
      do_scan((s < 5) ? 16'h0020 : 16'h0000, vcnt);
      checks++; if (vcnt != e_valid) begin errors++; $display("FAIL rearm_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
      checks++; if (key_held !== m_held) begin errors++; $display("FAIL rearm_held scan %0d: got %b want %b", s, key_held, m_held); end
      checks++; if (key_code !== 4'(m_code)) begin errors++; $display("FAIL rearm_code scan %0d: got %0d want %0d", s, key_code, m_code); end
    end
  endtask

  task automatic test_repeat();
    int vcnt;
    int total;
    total = 0;
    for (int s = 0; s < 19; s++) begin
      do_scan((s < 15) ? 16'h0008 : 16'h0000, vcnt);
      total += vcnt;
      checks++; if (vcnt != e_valid) begin errors++; $display("FAIL repeat_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
      checks++; if (key_code !== 4'(m_code)) begin errors++; $display("FAIL repeat_code scan %0d: got %0d want %0d", s, key_code, m_code); end
    end
`ifdef KEYPAD_REPEAT_EN
    checks++; if (total != 5) begin errors++; $display("FAIL repeat_total: got %0d want 5", total); end
`else
    checks++; if (total != 1) begin errors++; $display("FAIL repeat_total: got %0d want 1", total); end
`endif
  endtask

  task automatic test_random();
    int vcnt, a, b, pick, run;
    logic [15:0] k;
    a = $urandom_range(0, 15);
    b = (a + $urandom_range(1, 15)) % 16;
    for (int s = 0; s < 60; ) begin
      pick = $urandom_range(0, 3);
      run  = $urandom_range(1, 5);
      k = '0;
      if (pick == 1) k[a] = 1'b1;
      if (pick == 2) k[b] = 1'b1;
      if (pick == 3) begin k[a] = 1'b1; k[b] = 1'b1; k[$urandom_range(0, 15)] = 1'b1; end
      for (int r = 0; r < run && s < 60; r++, s++) begin
        do_scan(k, vcnt);
        checks++; if (vcnt != e_valid) begin errors++; $display("FAIL rand_valid scan %0d: got %0d want %0d", s, vcnt, e_valid); end
        checks++; if (key_held !== m_held) begin errors++; $display("FAIL rand_held scan %0d: got %b want %b", s, key_held, m_held); end
        checks++; if (key_code !== 4'(m_code)) begin errors++; $display("FAIL rand_code scan %0d: got %0d want %0d", s, key_code, m_code); end
        checks++; if (multi !== e_multi) begin errors++; $display("FAIL rand_multi scan %0d: got %b want %b", s, multi, e_multi); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_reset_mid_press();
    test_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan_zyq.md
# keypad_scan_zyq

Parametrised matrix-keypad scanner with per-key debounce, single-key event strobe, multi-key detection and optional auto-repeat. It is the next generation of the fixed 4x4 key getter in the top level: it drives active-low columns, samples active-low rows and hands a stable key code plus a one-cycle valid pulse to the work/control logic. It runs on the fast divided clock, upstream of the display path.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- CODE_W, 4, key code width; ROWS*COLS <= 2**CODE_W required
- SCAN_DIV, 1000, CLK cycles each column is driven (>= 3)
- DEBOUNCE, 4, consecutive identical full scans needed to commit a change (>= 1)
- REPEAT_DELAY, 50, full scans held before the first repeat (only with KEYPAD_REPEAT_EN)
- REPEAT_RATE, 10, full scans between later repeats (only with KEYPAD_REPEAT_EN)

- CLK  in  1  single clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- row_in  in  ROWS  row lines, active-low (pulled up), asynchronous to CLK
- col_out  out  COLS  column drive, exactly one bit low at any time
- key_code  out  CODE_W  code of committed key = row*COLS + col
- key_valid  out  1  one-cycle pulse per press event (and per repeat)
- key_held  out  1  high while a committed key is pressed
- multi  out  1  high while the last complete scan saw >= 2 keys

## Operation
- row_in passes through a 2-FF synchroniser before use.
- Tick counter 0..SCAN_DIV-1; column index 0..COLS-1 advances when the tick wraps; col_out = ~(1 << col).
- Rows are sampled on tick SCAN_DIV-1 (settled), into a ROWS*COLS scan image. After column COLS-1 is sampled, a "scan done" event classifies the image: NONE (0 keys), SINGLE(code) (exactly 1), MULTI (>= 2).
- Debounce: classification compared with previous scan's; identical increments a stability counter (saturating at DEBOUNCE), different resets it to 1.
- FSM, evaluated only on scan done:
  - IDLE: stable SINGLE(k) for DEBOUNCE scans -> PRESSED; latch key_code=k, pulse key_valid, key_held=1. NONE/MULTI -> stay, no event.
  - PRESSED: stable NONE for DEBOUNCE scans -> IDLE, key_held=0, key_code retained. Stable SINGLE of a different key or MULTI -> stay PRESSED, no event (release must be seen first).
- multi updates every scan done, independent of debounce.

## Timing
- Reset values: col_out = ~1 (column 0 driven), tick=0, column=0, state IDLE, key_code=0, key_valid=0, key_held=0, multi=0, stability counter 0, previous classification NONE.
- Full scan = COLS*SCAN_DIV cycles. key_valid/key_held/multi register on the cycle after scan done.
- Minimum press latency from stable synchronised rows: 2 sync cycles + up to one scan to align + DEBOUNCE scans.
- key_valid is never high two consecutive cycles.
- Reset mid-press: all outputs return to reset values immediately; a key still held is re-reported as a new press after DEBOUNCE scans.
- Bounce shorter than DEBOUNCE scans produces no event and no key_held change.

## Configuration
- KEYPAD_REPEAT_EN defined: in PRESSED with the same key stable, a scan counter pulses key_valid (same key_code) after REPEAT_DELAY scans, then every REPEAT_RATE scans; counter clears on entry to PRESSED and on reset.
- Not defined: exactly one key_valid per press; REPEAT_* ignored, repeat logic absent.

## Test plan
Bench params: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3 (scan = 16 cycles).
- Reset, no keys -> col_out walks 1110,1101,1011,0111 every 4 cycles; all outputs 0, no key_valid.
- Hold row 2 / column 1 -> one key_valid pulse with key_code=9, key_held=1 after 3 stable scans; release -> key_held=0 after 3 NONE scans, no extra pulse.
- Toggle the same key every scan for 10 scans -> no key_valid, key_held stays 0.
- Hold codes 0 and 15 together -> multi=1 after next scan, no key_valid; release one leaving 15 -> multi=0, then key_valid with key_code=15.
- Assert RST mid-hold of code 5 -> outputs zero asynchronously; deassert with key still held -> fresh key_valid code 5 after 3 scans.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold code 3 for 12 scans after commit -> key_valid pulses at commit, +5, +7, +9, +11 scans; without macro -> single pulse.
